// File: rtl/aes_pkg.sv
// Shared AES definitions: round-key geometry, RCON table and key-schedule state encoding.
package aes_pkg;

  localparam int RK_W   = 128;
  localparam int RK_NUM = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } ks_state_t;

  // Round constant for expansion step i (0..9); out-of-range steps give 0.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // Inverse as x^254 through an addition chain; 0 maps to 0 naturally.
  assign x2   = gf_mul(data, data);
  assign x3   = gf_mul(x2, data);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign inv  = gf_mul(gf_mul(x240, x12), x2);

  assign result = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_dec_key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry store, served by index.
module aes_dec_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [RK_W-1:0] key_in,
  output logic            key_ready,
  output logic            keys_valid,
  input  logic [3:0]      rd_idx,
  output logic [RK_W-1:0] rd_key,
  output ks_state_t       fsm_state
);

  // Handshake: a key is taken on any rising edge where key_valid && key_ready;
  // key_valid may stay high while key_ready is low and is simply not consumed.

  ks_state_t       state;
  logic [3:0]      n;
  logic [RK_W-1:0] cur_rk;
  logic [RK_W-1:0] next_rk;
  logic [RK_W-1:0] store [RK_NUM];

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0] rot, sub;

  assign w0  = cur_rk[127:96];
  assign w1  = cur_rk[95:64];
  assign w2  = cur_rk[63:32];
  assign w3  = cur_rk[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data   (rot[8*b +: 8]),
      .result (sub[8*b +: 8])
    );
  end

  assign w4      = w0 ^ sub ^ {rcon(n - 4'd1), 24'h0};
  assign w5      = w1 ^ w4;
  assign w6      = w2 ^ w5;
  assign w7      = w3 ^ w6;
  assign next_rk = {w4, w5, w6, w7};

  assign key_ready = (state != ST_EXPAND);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      n          <= 4'd0;
      keys_valid <= 1'b0;
      rd_key     <= '0;
      cur_rk     <= '0;
      for (int i = 0; i < RK_NUM; i++) store[i] <= '0;
    end else begin
      // Read sees the store before this edge's write.
      if (rd_idx < 4'(RK_NUM)) rd_key <= store[rd_idx];
      else                     rd_key <= '0;

      case (state)
        ST_IDLE, ST_READY: begin
          if (key_valid) begin
            store[0]   <= key_in;
            cur_rk     <= key_in;
            n          <= 4'd1;
            keys_valid <= 1'b0;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          store[n] <= next_rk;
          cur_rk   <= next_rk;
          if (n == 4'(NR)) begin
            keys_valid <= 1'b1;
            state      <= ST_READY;
          end else begin
            n <= n + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Directed bench for aes_dec_key_schedule with a word-level FIPS-197 expansion model.
module tb_aes_dec_key_schedule;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  ks_state_t    fsm_state;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_A    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_ONES = {128{1'b1}};

  always #5 clk = ~clk;

  aes_dec_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .fsm_state  (fsm_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[8*(15 - int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Cycle model: phase 0 = accepting, 1..10 = next round key to be written.
  logic [127:0] m_store [11];
  logic [127:0] m_key;
  logic [127:0] m_rd;
  logic         m_kv;
  int           m_phase;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) m_store[i] = '0;
      m_phase = 0;
      m_kv    = 1'b0;
      m_rd    = '0;
    end else begin
      if (rd_idx <= 4'd10) m_rd = m_store[rd_idx];
      else                 m_rd = '0;
      if (m_phase == 0) begin
        if (key_valid) begin
          m_key      = key_in;
          m_store[0] = key_in;
          m_phase    = 1;
          m_kv       = 1'b0;
        end
      end else begin
        m_store[m_phase] = round_key(m_key, m_phase);
        if (m_phase == 10) begin
          m_phase = 0;
          m_kv    = 1'b1;
        end else begin
          m_phase++;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_int("cyc_key_ready", int'(key_ready), int'(m_phase == 0));
      check_int("cyc_keys_valid", int'(keys_valid), int'(m_kv));
      check128("cyc_rd_key", rd_key, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic read_chk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rd_idx = idx;
    @(negedge clk);
    check128(name, rd_key, exp);
  endtask

  // Offers a key for one cycle and counts negedges until keys_valid is seen high.
  task automatic accept_timed(input logic [127:0] k, output int cnt);
    key_valid = 1'b1;
    key_in    = k;
    cnt       = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) key_valid = 1'b0;
    end while (!keys_valid && cnt < 40);
    if (cnt >= 40) check_int("keys_valid_timeout", cnt, 11);
  endtask

  int lat;
  int hold;

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 4'd0;

    // model pins against FIPS-197 literals
    check128("pin_fips_rk1", round_key(K_FIPS, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check128("pin_fips_rk10", round_key(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check128("pin_zero_rk10", round_key(128'h0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check_int("rst_key_ready", int'(key_ready), 1);
    check_int("rst_keys_valid", int'(keys_valid), 0);
    check128("rst_rd_key", rd_key, '0);
    rst = 1'b0;

    // FIPS-197 key
    accept_timed(K_FIPS, lat);
    check_int("fips_valid_latency", lat, 11);
    read_chk("fips_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_chk("fips_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_chk("fips_rk0", 4'd0, K_FIPS);

    // reverse stream, one index per cycle
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      @(negedge clk);
      check128("rev_stream", rd_key, round_key(K_FIPS, i));
    end
    read_chk("idx12_zero", 4'd12, '0);

    // key B held high from three cycles after accepting A
    key_valid = 1'b1;
    key_in    = K_A;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    key_valid = 1'b1;
    key_in    = K_B;
    hold      = 0;
    do begin
      @(negedge clk);
      hold++;
    end while (!key_ready && hold < 40);
    check_int("held_wait", hold, 8);
    check_int("held_a_done", int'(keys_valid), 1);
    @(negedge clk);
    key_valid = 1'b0;
    check_int("held_b_drop_valid", int'(keys_valid), 0);
    check_int("held_b_busy", int'(key_ready), 0);
    hold = 0;
    while (!keys_valid && hold < 40) begin
      @(negedge clk);
      hold++;
    end
    check_int("held_b_latency", hold, 10);
    read_chk("held_b_rk10", 4'd10, round_key(K_B, 10));
    read_chk("held_b_rk0", 4'd0, K_B);

    // reset at expansion cycle 5
    key_valid = 1'b1;
    key_in    = K_A;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("midrst_keys_valid", int'(keys_valid), 0);
    check128("midrst_rd_key", rd_key, '0);
    check_int("midrst_key_ready", int'(key_ready), 1);
    for (int i = 0; i <= 10; i++) read_chk("midrst_store_zero", 4'(i), '0);

    // rekey in READY: all-zero then all-ones
    accept_timed(128'h0, lat);
    check_int("zero_valid_latency", lat, 11);
    read_chk("zero_rk10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    accept_timed(K_ONES, lat);
    check_int("rekey_gap", lat, 11);
    read_chk("ones_rk10", 4'd10, round_key(K_ONES, 10));

    // rst and key_valid together: key not taken
    rst       = 1'b1;
    key_valid = 1'b1;
    key_in    = K_FIPS;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    check_int("rstkv_key_ready", int'(key_ready), 1);
    check_int("rstkv_keys_valid", int'(keys_valid), 0);
    repeat (12) begin
      @(negedge clk);
      check_int("rstkv_stays_invalid", int'(keys_valid), 0);
    end
    read_chk("rstkv_rk0_zero", 4'd0, '0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
